// File: rtl/mux_scan_capture.sv
// mux_scan_capture: walks the select of an N:1 1-bit mux, captures one bit per clock
// and presents the assembled N-bit word behind a valid/ready handshake.
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request one scan (sampled in IDLE and HOLD only)
//   cont      in   continuous mode: rescan after every accepted word
//   sel       out  registered mux select, always < NUM_OF_INPUTS
//   f         in   mux output for the current sel
//   data_out  out  captured word, bit k = f seen while sel==k
//   out_valid out  data_out holds a complete word
//   out_ready in   downstream accepts the word
//   busy      out  high while scanning
module mux_scan_capture #(
    parameter int NUM_OF_INPUTS = 5,
    parameter int SEL_W = $clog2(NUM_OF_INPUTS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cont,
    output logic [SEL_W-1:0]         sel,
    input  logic                     f,
    output logic [NUM_OF_INPUTS-1:0] data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OF_INPUTS - 1);
    state_t                   state_q, state_d;
    logic [SEL_W-1:0]         cnt_q, cnt_d;
    logic [NUM_OF_INPUTS-1:0] shadow_q, shadow_d;
    logic [NUM_OF_INPUTS-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     req;
    assign req = start | cont;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                shadow_d[cnt_q] = f;
                if (cnt_q == LAST) begin
                    // The last bit goes straight from f into the word; shadow
                    // only holds it after this edge.
                    data_d  = {f, shadow_q[NUM_OF_INPUTS-2:0]};
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                // Requests only count on the handshake edge; nothing is latched while stalled.
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = req ? SCAN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SCAN);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end
    // The select is the scan counter itself, so sel==cnt holds by construction.
    assign sel       = cnt_q;
    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mux_scan_capture.sv
// tb_mux_scan_capture: directed and randomized checks of mux_scan_capture (N=5 and N=8)
// against a reference that builds each expected word from the mux inputs driven per cycle.
module tb_mux_scan_capture;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, cont = 1'b0, out_ready = 1'b0;
    logic [4:0] a = '0;
    logic [2:0] sel;
    logic       f;
    logic [4:0] data_out;
    logic       out_valid, busy;
    logic       start8 = 1'b0, cont8 = 1'b0, ready8 = 1'b1;
    logic [7:0] a8 = 8'hA5;
    logic [2:0] sel8;
    logic       f8;
    logic [7:0] data8;
    logic       valid8, busy8;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;
    assign f  = (sel < 3'd5) ? a[sel] : 1'bx;
    assign f8 = a8[sel8];

    mux_scan_capture #(.NUM_OF_INPUTS(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .sel(sel), .f(f),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );
    mux_scan_capture #(.NUM_OF_INPUTS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .cont(cont8), .sel(sel8), .f(f8),
        .data_out(data8), .out_valid(valid8), .out_ready(ready8), .busy(busy8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hold(input logic [4:0] w);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(data_out), 32'(w));
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_sel", 32'(sel), 32'd0);
    endtask

    // Runs the N scan cycles from the cycle right after the accepting edge.
    // pat[i] is the mux input vector held during cycle i; the word the scanner
    // must build takes bit i from pat[i]. Noise on start/out_ready/cont is ignored in SCAN.
    task automatic scan_cycles(input logic [4:0][4:0] pat, input bit noise, output logic [4:0] w);
        for (int i = 0; i < 5; i++) begin
            chk("scan_sel", 32'(sel), 32'(i));
            chk("scan_busy", 32'(busy), 32'd1);
            chk("scan_valid", 32'(out_valid), 32'd0);
            a = pat[i];
            w[i] = pat[i][i];
            if (noise) begin
                start = 1'($urandom);
                out_ready = 1'($urandom);
                cont = 1'($urandom);
            end
            tick();
        end
        start = 1'b0;
        cont = 1'b0;
        out_ready = 1'b0;
        chk_hold(w);
    endtask

    task automatic fill(input logic [4:0] v, output logic [4:0][4:0] pat);
        for (int i = 0; i < 5; i++) pat[i] = v;
    endtask

    initial begin
        logic [4:0][4:0] pat;
        logic [4:0]      w, last;
        bit              in_scan;
        int              d;
        int              idle_n;
        // Reset state
        #2;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Single scan with out_ready high throughout
        fill(5'b10110, pat);
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        scan_cycles(pat, 1'b0, w);
        chk("t1_word", 32'(w), 32'h16);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_valid_drop", 32'(out_valid), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_sel", 32'(sel), 32'd0);
        chk("t1_data_kept", 32'(data_out), 32'h16);

        // Backpressure: start during a stalled HOLD must not be latched
        fill(5'b01001, pat);
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_cycles(pat, 1'b0, w);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
            chk_hold(5'b01001);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        chk("bp_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("bp_still_idle", 32'(busy), 32'd0);
        chk("bp_data_kept", 32'(data_out), 32'h09);

        // Continuous mode: back-to-back words, 6 clocks apart
        cont = 1'b1;
        tick();
        fill(5'b11111, pat);
        scan_cycles(pat, 1'b0, w);
        a = 5'b00011;
        cont = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("cont_rescan_busy", 32'(busy), 32'd1);
        chk("cont_valid_pulse", 32'(out_valid), 32'd0);
        cont = 1'b1;
        fill(5'b00011, pat);
        for (int i = 0; i < 5; i++) begin
            chk("cont_sel", 32'(sel), 32'(i));
            chk("cont_valid_low", 32'(out_valid), 32'd0);
            a = pat[i];
            tick();
        end
        chk_hold(5'b00011);
        cont = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("cont_idle", 32'(busy), 32'd0);

        // Mux input changes mid-scan: a[4] rises while sel==2
        pat[0] = 5'b00000;
        pat[1] = 5'b00000;
        pat[2] = 5'b10000;
        pat[3] = 5'b10000;
        pat[4] = 5'b10000;
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_cycles(pat, 1'b0, w);
        chk("mid_word", 32'(w), 32'h10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Randomized scans with random stalls, cont decisions and ignored noise
        in_scan = 1'b0;
        last = 5'h10;
        for (int n = 0; n < 30; n++) begin
            if (!in_scan) begin
                idle_n = $urandom_range(0, 2);
                for (int k = 0; k < idle_n; k++) begin
                    out_ready = 1'($urandom);
                    tick();
                    chk("rnd_idle_busy", 32'(busy), 32'd0);
                    chk("rnd_idle_data", 32'(data_out), 32'(last));
                end
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            for (int i = 0; i < 5; i++) pat[i] = 5'($urandom);
            scan_cycles(pat, 1'b1, w);
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin
                start = 1'($urandom);
                cont = 1'($urandom);
                tick();
                chk_hold(w);
            end
            in_scan = 1'($urandom);
            start = in_scan & 1'($urandom);
            cont = in_scan & ~start;
            out_ready = 1'b1;
            tick();
            start = 1'b0;
            cont = 1'b0;
            out_ready = 1'b0;
            last = w;
            chk("rnd_valid_drop", 32'(out_valid), 32'd0);
            chk("rnd_exit_busy", 32'(busy), 32'(in_scan));
            chk("rnd_exit_sel", 32'(sel), 32'd0);
        end
        if (in_scan) begin
            fill(5'b0, pat);
            scan_cycles(pat, 1'b0, w);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Asynchronous reset in the middle of a scan, between clock edges
        fill(5'b11011, pat);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("ar_sel_pre", 32'(sel), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sel", 32'(sel), 32'd0);
        chk("ar_data", 32'(data_out), 32'd0);
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_no_valid", 32'(out_valid), 32'd0);
        fill(5'b00101, pat);
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_cycles(pat, 1'b0, w);
        chk("ar_word", 32'(w), 32'h05);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Power-of-two width: N=8
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("n8_sel", 32'(sel8), 32'(i));
            chk("n8_busy", 32'(busy8), 32'd1);
            tick();
        end
        chk("n8_valid", 32'(valid8), 32'd1);
        chk("n8_data", 32'(data8), 32'hA5);
        tick();
        chk("n8_valid_drop", 32'(valid8), 32'd0);
        chk("n8_idle_sel", 32'(sel8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
